rf_wport_arbiter: RTL and testbench

//  Shares the single regfile write port between the in-order WB stage and a

---
 rtl/rf_wport_arbiter_pkg.sv | 22 ++
 rtl/rf_wq_fifo.sv | 62 ++++++
 rtl/rf_wport_arbiter.sv | 115 +++++++++++
 tb/tb_rf_wport_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter and its LU result queue.
package rf_wport_arbiter_pkg;

  localparam int unsigned RegAddrW     = 5;
  localparam int unsigned DataW        = 32;
  localparam int unsigned LuToArbBusWd = 69;
  localparam int unsigned RfWportDepth = 2;

  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic [DataW-1:0]    data;
    logic [DataW-1:0]    pc;
  } lu_entry_t;

  function automatic logic [DataW-1:0] reg_onehot(input logic [RegAddrW-1:0] a);
    logic [DataW-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rf_wq_fifo.sv
// Synchronous FIFO holding LU results until they win the regfile write port.
module rf_wq_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = RfWportDepth,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push,
  input  logic            pop,
  input  lu_entry_t       din,
  output lu_entry_t       head,
  output logic [CntW-1:0] count,
  output lu_entry_t       slots [DEPTH],
  output logic [DEPTH-1:0] slot_valid
);

  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [DEPTH-1:0] vld_q;
  lu_entry_t        mem_q [DEPTH];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q        <= ptr_inc(rd_ptr_q);
        vld_q[rd_ptr_q] <= 1'b0;
      end
      if (push) begin
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
        vld_q[wr_ptr_q] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset: slot_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign slots      = mem_q;
  assign slot_valid = vld_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port between WB (priority) and queued long-latency results,
// holding WB for one cycle whenever the queue head has aged out.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = RfWportDepth,
  parameter int unsigned AGE_MAX = 4,
  localparam int unsigned CntW   = $clog2(DEPTH + 1),
  localparam int unsigned AgeW   = $clog2(AGE_MAX + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_req_we,
  input  logic [4:0]  ws_req_addr,
  input  logic [31:0] ws_req_data,
  input  logic [31:0] ws_req_pc,
  output logic        ws_hold,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  lu_entry_t        lu_in, head;
  lu_entry_t        slots [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [CntW-1:0]  count;
  logic [AgeW-1:0]  age_q, age_d;
  logic             qne, starve, pop, push, ws_grant;
  logic [31:0]      wpc;

  assign lu_in = '{addr: lu_addr, data: lu_data, pc: lu_pc};

  assign qne      = (count != '0);
  assign starve   = qne && (age_q == AgeW'(AGE_MAX));
  assign pop      = qne && (!ws_req_we || starve);
  assign ws_hold  = ws_req_we && starve;
  // Gated by reset so nothing reaches the regfile while held in reset.
  assign ws_grant = ws_req_we && !ws_hold && resetn;
  assign lu_ready = (count < CntW'(DEPTH));
  // r0 results complete the handshake but are never written.
  assign push     = lu_valid && lu_ready && (lu_addr != '0);

  rf_wq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .pop       (pop),
    .din       (lu_in),
    .head      (head),
    .count     (count),
    .slots     (slots),
    .slot_valid(slot_valid)
  );

  always_comb begin
    age_d = age_q;
    if (!qne || pop) begin
      age_d = '0;
    end else if (age_q != AgeW'(AGE_MAX)) begin
      age_d = age_q + AgeW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (slot_valid[i]) pend_mask = pend_mask | reg_onehot(slots[i].addr);
    end
    pend_mask[0] = 1'b0;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    wpc      = '0;
    if (ws_grant) begin
      rf_we    = 1'b1;
      rf_waddr = ws_req_addr;
      rf_wdata = ws_req_data;
      wpc      = ws_req_pc;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = head.addr;
      rf_wdata = head.data;
      wpc      = head.pc;
    end
  end

  assign debug_wb_pc       = wpc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench: LU handshakes queue expected writes, every regfile write is checked.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  logic        clk, resetn;
  logic        ws_req_we, ws_hold, lu_valid, lu_ready, rf_we;
  logic [4:0]  ws_req_addr, lu_addr, rf_waddr, debug_wb_rf_wnum;
  logic [31:0] ws_req_data, ws_req_pc, lu_data, lu_pc, rf_wdata, pend_mask;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  lu_entry_t   lu_exp[$];
  logic [4:0]  lu_written[$];

  rf_wport_arbiter u_dut (
    .clk              (clk),
    .resetn           (resetn),
    .ws_req_we        (ws_req_we),
    .ws_req_addr      (ws_req_addr),
    .ws_req_data      (ws_req_data),
    .ws_req_pc        (ws_req_pc),
    .ws_hold          (ws_hold),
    .lu_valid         (lu_valid),
    .lu_ready         (lu_ready),
    .lu_addr          (lu_addr),
    .lu_data          (lu_data),
    .lu_pc            (lu_pc),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .pend_mask        (pend_mask),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ws(input logic we, input logic [4:0] a, input logic [31:0] d);
    ws_req_we   = we;
    ws_req_addr = a;
    ws_req_data = d;
    ws_req_pc   = 32'h1000 + {d[29:0], 2'b00};
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v;
    lu_addr  = a;
    lu_data  = d;
    lu_pc    = 32'h8000 + {d[29:0], 2'b00};
  endtask

  // Monitor: WB must win unless held; otherwise the oldest handshaken LU result is due.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (ws_req_we && !ws_hold) begin
        check("wb_we", {31'd0, rf_we}, 32'd1);
        check("wb_addr", {27'd0, rf_waddr}, {27'd0, ws_req_addr});
        check("wb_data", rf_wdata, ws_req_data);
        check("wb_pc", debug_wb_pc, ws_req_pc);
      end else if (rf_we) begin
        if (lu_exp.size() == 0) begin
          check("lu_spurious_we", {31'd0, rf_we}, 32'd0);
        end else begin
          lu_entry_t e;
          e = lu_exp.pop_front();
          lu_written.push_back(rf_waddr);
          check("lu_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
          check("lu_data", debug_wb_rf_wdata, e.data);
          check("lu_pc", debug_wb_pc, e.pc);
          check("lu_wen", {28'd0, debug_wb_rf_wen}, 32'hf);
        end
      end else if (lu_exp.size() != 0) begin
        check("lu_stuck", {31'd0, rf_we}, 32'd1);
      end
      if (lu_valid && lu_ready && lu_addr != 5'd0)
        lu_exp.push_back('{addr: lu_addr, data: lu_data, pc: lu_pc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    resetn = 1'b0;
    drive_ws(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    #12;
    check("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_hold", {31'd0, ws_hold}, 32'd0);
    check("rst_pend", pend_mask, 32'd0);
    check("rst_dbg_pc", debug_wb_pc, 32'd0);
    tick();
    resetn = 1'b1;

    // WB alone: same-cycle write
    tick();
    drive_ws(1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    check("wb_only_we", {31'd0, rf_we}, 32'd1);
    check("wb_only_addr", {27'd0, debug_wb_rf_wnum}, 32'd5);
    check("wb_only_data", rf_wdata, 32'h1234);
    tick();
    drive_ws(1'b0, 5'd0, 32'd0);

    // LU with idle WB: written one cycle after handshake
    drive_lu(1'b1, 5'd8, 32'hA);
    @(negedge clk);
    check("lu_hs_ready", {31'd0, lu_ready}, 32'd1);
    check("lu_hs_no_bypass", {31'd0, rf_we}, 32'd0);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("lu_lat_we", {31'd0, rf_we}, 32'd1);
    check("lu_lat_addr", {27'd0, rf_waddr}, 32'd8);
    check("lu_lat_pend", pend_mask, 32'h0000_0100);
    tick();
    @(negedge clk);
    check("lu_after_we", {31'd0, rf_we}, 32'd0);
    check("lu_after_pend", pend_mask, 32'd0);
    tick();

    // Starvation: WB wins 4 cycles, 5th is held for the LU head, 6th WB again
    drive_ws(1'b1, 5'd10, 32'h100);
    drive_lu(1'b1, 5'd9, 32'h99);
    @(negedge clk);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      drive_ws(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      @(negedge clk);
      check($sformatf("starve_hold_%0d", i), {31'd0, ws_hold}, (i == 5) ? 32'd1 : 32'd0);
      check($sformatf("starve_addr_%0d", i), {27'd0, rf_waddr},
            (i == 5) ? 32'd9 : 32'(10 + i));
      if (i == 1) check("starve_pend", pend_mask, 32'h0000_0200);
      tick();
    end
    drive_ws(1'b0, 5'd0, 32'd0);
    tick();

    // r0 result: handshake only
    drive_lu(1'b1, 5'd0, 32'h77);
    @(negedge clk);
    check("r0_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("r0_no_we", {31'd0, rf_we}, 32'd0);
    check("r0_pend", pend_mask, 32'd0);
    check("r0_ready_after", {31'd0, lu_ready}, 32'd1);
    tick();

    // Full queue under continuous WB: third result stalls, order 3,4,5 kept
    lu_written.delete();
    drive_ws(1'b1, 5'd16, 32'h200);
    drive_lu(1'b1, 5'd3, 32'h3);
    @(negedge clk);
    tick();
    drive_lu(1'b1, 5'd4, 32'h4);
    @(negedge clk);
    tick();
    drive_lu(1'b1, 5'd5, 32'h5);
    @(negedge clk);
    check("full_ready", {31'd0, lu_ready}, 32'd0);
    check("full_pend", pend_mask, 32'h0000_0018);
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      tick();
      @(negedge clk);
      hs = lu_ready;
    end
    check("full_unstall", {31'd0, hs}, 32'd1);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    drive_ws(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 10 && lu_exp.size() != 0; k++) tick();
    tick();
    check("full_drain", 32'(lu_exp.size()), 32'd0);
    check("full_nwritten", 32'(lu_written.size()), 32'd3);
    if (lu_written.size() == 3) begin
      check("full_order0", {27'd0, lu_written[0]}, 32'd3);
      check("full_order1", {27'd0, lu_written[1]}, 32'd4);
      check("full_order2", {27'd0, lu_written[2]}, 32'd5);
    end

    // Async reset with a full queue discards it immediately
    drive_ws(1'b1, 5'd17, 32'h300);
    drive_lu(1'b1, 5'd20, 32'h20);
    @(negedge clk);
    tick();
    drive_lu(1'b1, 5'd21, 32'h21);
    @(negedge clk);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("pre_rst_ready", {31'd0, lu_ready}, 32'd0);
    check("pre_rst_pend", pend_mask, 32'h0030_0000);
    tick();
    resetn = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, lu_ready}, 32'd1);
    check("mid_rst_pend", pend_mask, 32'd0);
    check("mid_rst_we", {31'd0, rf_we}, 32'd0);
    check("mid_rst_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    check("mid_rst_hold", {31'd0, ws_hold}, 32'd0);
    lu_exp.delete();
    drive_ws(1'b0, 5'd0, 32'd0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_we", {31'd0, rf_we}, 32'd0);
    check("post_rst_pend", pend_mask, 32'd0);
    tick();

    // Random mix, checked by the monitor
    for (int k = 0; k < 120; k++) begin
      drive_ws(1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom);
      drive_lu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      tick();
    end
    drive_ws(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 10 && lu_exp.size() != 0; k++) tick();
    tick();
    check("final_sb_empty", 32'(lu_exp.size()), 32'd0);
    check("final_pend", pend_mask, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
